// File: rtl/register_file_if.sv
// Register-file bus: one write port (write-back) and two combinational read ports.
// The master drives indices and write data; the slave returns the operands.
interface register_file_if #(
    parameter int N_BITS = 32
) ();
    logic              Reg_Write_i;
    logic [4:0]        Write_Register_i;
    logic [N_BITS-1:0] Write_Data_i;
    logic [4:0]        Read_Register_1_i;
    logic [4:0]        Read_Register_2_i;
    logic [N_BITS-1:0] Read_Data_1_o;
    logic [N_BITS-1:0] Read_Data_2_o;

    modport master (
        output Reg_Write_i, Write_Register_i, Write_Data_i,
        output Read_Register_1_i, Read_Register_2_i,
        input  Read_Data_1_o, Read_Data_2_o
    );

    modport slave (
        input  Reg_Write_i, Write_Register_i, Write_Data_i,
        input  Read_Register_1_i, Read_Register_2_i,
        output Read_Data_1_o, Read_Data_2_o
    );
endinterface

// File: rtl/register_file.sv
// 32 x N_BITS integer register file: x0 hardwired to zero, x2/x3 preset to sp/gp,
// asynchronous reads with no write bypass, single write port committed on the rising edge.
module register_file #(
    parameter int                N_BITS   = 32,
    parameter logic [N_BITS-1:0] SP_RESET = 32'h7FFF_EFFC,
    parameter logic [N_BITS-1:0] GP_RESET = 32'h1000_8000
) (
    input  logic           clk,
    input  logic           reset,
    register_file_if.slave rf_bus
);

    // x0 has no storage element; only x1..x31 are flops.
    logic [N_BITS-1:0] regs_q    [1:31];
    logic [N_BITS-1:0] regs_d    [1:31];
    logic [N_BITS-1:0] rd_view_s [0:31];

    function automatic logic [N_BITS-1:0] reset_value(input logic [4:0] idx);
        logic [N_BITS-1:0] val;
        case (idx)
            5'd2:    val = SP_RESET;
            5'd3:    val = GP_RESET;
            default: val = {N_BITS{1'b0}};
        endcase
        return val;
    endfunction

    // Next state: the enable qualifies the decode, so an unknown index with the enable low holds every entry
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            if (rf_bus.Reg_Write_i && (rf_bus.Write_Register_i == 5'(i))) begin
                regs_d[i] = rf_bus.Write_Data_i;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Storage: asynchronous reset to the preset values, otherwise load next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= reset_value(5'(i));
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read view: index 0 is a constant zero, the rest mirror storage
    always_comb begin
        rd_view_s[0] = {N_BITS{1'b0}};
        for (int i = 1; i < 32; i++) begin
            rd_view_s[i] = regs_q[i];
        end
    end

    assign rf_bus.Read_Data_1_o = rd_view_s[rf_bus.Read_Register_1_i];
    assign rf_bus.Read_Data_2_o = rd_view_s[rf_bus.Read_Register_2_i];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected operands from an
// array-based architectural model, a separate monitor pops and compares them.
module tb_register_file;

    localparam logic [31:0] SP_RST = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_RST = 32'h1000_8000;

    logic clk;
    logic reset;

    register_file_if #(.N_BITS(32)) bus ();

    register_file #(
        .N_BITS  (32),
        .SP_RESET(SP_RST),
        .GP_RESET(GP_RST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rf_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] model [32];
    string       q_name [$];
    logic [31:0] q_e1 [$];
    logic [31:0] q_e2 [$];
    event        sample_ev;
    int          checks = 0;
    int          errors = 0;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[2] = SP_RST;
        model[3] = GP_RST;
    endfunction

    function automatic logic [31:0] arch_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : model[idx];
    endfunction

    // Monitor: each time the bench samples the read ports, compare against the oldest expectation
    initial begin
        forever begin
            @(sample_ev);
            if (q_name.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got sample with no expectation, required a queued entry");
            end else begin
                string       nm;
                logic [31:0] e1;
                logic [31:0] e2;
                nm = q_name.pop_front();
                e1 = q_e1.pop_front();
                e2 = q_e2.pop_front();
                checks++;
                if (bus.Read_Data_1_o !== e1) begin
                    errors++;
                    $display("FAIL %s rd1: rs1=%0d got %h required %h", nm, bus.Read_Register_1_i, bus.Read_Data_1_o, e1);
                end
                checks++;
                if (bus.Read_Data_2_o !== e2) begin
                    errors++;
                    $display("FAIL %s rd2: rs2=%0d got %h required %h", nm, bus.Read_Register_2_i, bus.Read_Data_2_o, e2);
                end
            end
        end
    end

    task automatic check_read(input logic [4:0] rs1, input logic [4:0] rs2, input string nm);
        bus.Read_Register_1_i = rs1;
        bus.Read_Register_2_i = rs2;
        #1;
        q_name.push_back(nm);
        q_e1.push_back(arch_read(rs1));
        q_e2.push_back(arch_read(rs2));
        -> sample_ev;
        #1;
    endtask

    task automatic sweep(input string nm);
        for (int i = 0; i < 32; i++) check_read(5'(i), 5'(31 - i), nm);
    endtask

    task automatic set_write(input logic en, input logic [4:0] rd, input logic [31:0] data);
        bus.Reg_Write_i      = en;
        bus.Write_Register_i = rd;
        bus.Write_Data_i     = data;
    endtask

    // One rising edge; the model commits the write the architecture allows, then the enable drops.
    task automatic tick();
        @(posedge clk);
        if (!reset && bus.Reg_Write_i && bus.Write_Register_i != 5'd0)
            model[bus.Write_Register_i] = bus.Write_Data_i;
        @(negedge clk);
        bus.Reg_Write_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        set_write(1'b0, 5'd0, 32'h0);
        bus.Read_Register_1_i = 5'd0;
        bus.Read_Register_2_i = 5'd0;

        // Asynchronous reset mid-cycle, before any clock edge.
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        sweep("reset_sweep");

        // Writes ignored while reset is high.
        @(negedge clk);
        set_write(1'b1, 5'd9, 32'hCAFE_F00D);
        tick();
        check_read(5'd9, 5'd2, "write_in_reset");
        reset = 1'b0;

        // Basic write, no bypass before the edge.
        set_write(1'b1, 5'd5, 32'hDEAD_BEEF);
        check_read(5'd5, 5'd5, "no_bypass");
        tick();
        check_read(5'd5, 5'd5, "basic_write");

        // x0 protection.
        set_write(1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        check_read(5'd0, 5'd0, "x0_write");
        sweep("x0_sweep");

        // Enable gating.
        for (int k = 0; k < 3; k++) begin
            set_write(1'b0, 5'd7, 32'h1234_5678);
            tick();
        end
        check_read(5'd7, 5'd0, "en_low");
        set_write(1'b1, 5'd7, 32'h1234_5678);
        tick();
        check_read(5'd7, 5'd7, "en_high");

        // Dual-port independence and swap.
        set_write(1'b1, 5'd10, 32'h0000_000A);
        tick();
        set_write(1'b1, 5'd11, 32'hFFFF_FFF6);
        tick();
        check_read(5'd10, 5'd11, "dual_port");
        check_read(5'd11, 5'd10, "dual_swap");

        // Consecutive writes to one register keep the last value.
        set_write(1'b1, 5'd12, 32'h1111_1111);
        tick();
        set_write(1'b1, 5'd12, 32'h2222_2222);
        tick();
        check_read(5'd12, 5'd12, "last_write");

        // Unknown write index with enable low disturbs nothing.
        set_write(1'b0, 5'bxxxxx, 32'hA5A5_A5A5);
        tick();
        sweep("x_index");

        // Reset coincident with a write.
        set_write(1'b1, 5'd2, 32'h0000_1000);
        tick();
        set_write(1'b1, 5'd20, 32'h55AA_55AA);
        tick();
        check_read(5'd2, 5'd20, "pre_reset");
        set_write(1'b1, 5'd20, 32'h0000_0001);
        @(posedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        bus.Reg_Write_i = 1'b0;
        check_read(5'd2, 5'd20, "coincident_reset");
        reset = 1'b0;
        check_read(5'd20, 5'd3, "after_deassert");
        set_write(1'b1, 5'd20, 32'h0000_0001);
        tick();
        check_read(5'd20, 5'd2, "first_edge_write");

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int it = 0; it < 150; it++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 31));
            set_write(1'($urandom_range(0, 1)), rd, $urandom);
            check_read(rd, 5'($urandom_range(0, 31)), "rand_pre");
            tick();
            check_read(5'($urandom_range(0, 31)), rd, "rand_post");
            if ((it % 50) == 49) begin
                #1;
                reset = 1'b1;
                model_reset();
                check_read(5'd2, 5'd3, "rand_reset");
                reset = 1'b0;
                @(negedge clk);
            end
        end

        #2;
        checks++;
        if (q_name.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q_name.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit integer register file (x0..x31) for the single-cycle RISC-V core.
- Sits directly upstream of the ALU: read port 1 drives the ALU A operand; read port 2 drives the B operand through the immediate mux.
- The write port takes the write-back value (ALU result, memory data or PC+4), committed on the rising clock edge.
- x0 is hardwired to zero. x2 (sp) and x3 (gp) take nonzero reset values so programs can run straight out of reset.

Parameters:
N_BITS, 32, data width of every register and data port
SP_RESET, 32'h7FFF_EFFC, reset value of x2 (stack pointer)
GP_RESET, 32'h1000_8000, reset value of x3 (global pointer)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
Reg_Write_i  input  1  write enable for the write port
Write_Register_i  input  5  destination register index (rd)
Write_Data_i  input  N_BITS  write-back data
Read_Register_1_i  input  5  source register index rs1
Read_Register_2_i  input  5  source register index rs2
Read_Data_1_o  output  N_BITS  contents of register rs1 (to ALU A_i)
Read_Data_2_o  output  N_BITS  contents of register rs2 (to ALU B_i mux / store data)

Behaviour:
- Clocking: one clock domain, clk. reset is asynchronous and active-high.
- Reset:
  - Asserting reset forces, immediately and independent of clk: x2 = SP_RESET, x3 = GP_RESET, every other register = 0.
  - Read outputs reflect these values combinationally while reset is high.
  - Writes are ignored while reset is high.
  - Reset may be asserted mid-operation. A write whose edge coincides with reset assertion is lost.
  - The first edge after reset deassertion performs a normal write.
- Write port:
  - When Reg_Write_i = 1 and reset = 0, Write_Data_i is stored into register Write_Register_i on the rising edge of clk. Latency is one edge.
  - When Reg_Write_i = 0, no register changes.
  - Write_Register_i = 0 with Reg_Write_i = 1 is a legal no-op: x0 stays 0 and no other register is disturbed.
- Read ports:
  - Both reads are purely combinational and asynchronous, so the ALU sees operands in the same cycle.
  - Index 0 always returns 0, regardless of storage contents.
  - No write-to-read bypass: in the cycle a register is being written, reads of it return the old value. The new value appears after the edge. This is correct for single-cycle operation.
  - Both ports may address the same register simultaneously. Both return the identical value.
- x0 storage: the implementation must never hold a nonzero value in x0. Either omit the storage element, or gate both the write and the read.
- Width rules: no sign extension or truncation inside the block. Data passes through bit-exact. Unknown (X) index inputs must not corrupt any register when Reg_Write_i = 0.
- Storage: entries x1..x31 are plain flip-flops with enable. Multiple writes to the same register on consecutive edges leave the last value.

Test Plan:
1. Reset check: assert reset asynchronously mid-cycle, sweep Read_Register_1_i over 0..31 -> x2 reads 32'h7FFF_EFFC, x3 reads 32'h1000_8000, all others read 0, with no clock edge required.
2. Basic write/read: Reg_Write_i=1, rd=5, data 32'hDEAD_BEEF, clock once, rs1=5, rs2=5 -> both outputs 32'hDEAD_BEEF. Before the edge, the same reads return 0 (no bypass).
3. x0 protection: write 32'hFFFF_FFFF to rd=0, clock, then read rs1=0 and rs2=0 -> both 0. x1..x31 are unchanged.
4. Enable gating: Reg_Write_i=0, rd=7, data 32'h1234_5678, clock several edges -> x7 stays 0. Then enable for one edge -> x7 = 32'h1234_5678.
5. Dual-port independence: write x10=32'h0000_000A and x11=32'hFFFF_FFF6 on successive edges. Read rs1=10, rs2=11 -> 32'h0000_000A / 32'hFFFF_FFF6. Swap the indices -> the outputs swap.
6. Reset mid-operation: after writing x2=32'h0000_1000 and x20=32'h55AA_55AA, assert reset coincident with a write of x20=32'h1 -> x2 returns to SP_RESET, x20 reads 0, and the coincident write is lost.
